// File: rtl/aes_pkg.sv
// Shared constants, FSM encoding and GF(2^8) helpers for the iterative AES-128 core.
package aes_pkg;

    localparam int unsigned NR      = 10;
    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned RC_W    = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seq_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box computed as a^254 (multiplicative inverse, 0 -> 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int unsigned i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_round_sequencer_round.sv
// One combinational AES-128 round plus the matching key-schedule step; FINAL drops MixColumns.
module aes_round_sequencer_round #(
    parameter bit          FINAL = 1'b0,
    parameter int unsigned RC_W  = 4
) (
    input  logic [127:0]    state_i,
    input  logic [127:0]    key_i,
    input  logic [RC_W-1:0] rc_i,
    output logic [127:0]    state_o,
    output logic [127:0]    key_o
);
    import aes_pkg::*;

    logic [7:0]   rcon;
    logic [31:0]  temp;
    logic [31:0]  w0;
    logic [31:0]  w1;
    logic [31:0]  w2;
    logic [31:0]  w3;
    logic [127:0] sr;
    logic [127:0] mc;

    function automatic logic [31:0] mix_col(input logic [31:0] a);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        a0 = a[31:24];
        a1 = a[23:16];
        a2 = a[15:8];
        a3 = a[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    always_comb begin
        rcon = 8'h01;
        for (int unsigned i = 1; i < 16; i++) begin
            if (i < 32'(rc_i)) rcon = xtime(rcon);
        end
        temp = {sbox(key_i[23:16]), sbox(key_i[15:8]), sbox(key_i[7:0]), sbox(key_i[31:24])}
             ^ {rcon, 24'h000000};
        w0    = key_i[127:96] ^ temp;
        w1    = key_i[95:64]  ^ w0;
        w2    = key_i[63:32]  ^ w1;
        w3    = key_i[31:0]   ^ w2;
        key_o = {w0, w1, w2, w3};
    end

    // Byte n = row + 4*col sits at bits [127-8n -: 8]; SubBytes and ShiftRows are fused.
    always_comb begin
        sr = '0;
        mc = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                sr[127 - 8*(r + 4*c) -: 8] = sbox(state_i[127 - 8*(r + 4*((c + r) % 4)) -: 8]);
            end
        end
        for (int unsigned c = 0; c < 4; c++) begin
            mc[127 - 32*c -: 32] = mix_col(sr[127 - 32*c -: 32]);
        end
        state_o = (FINAL ? sr : mc) ^ key_o;
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 controller: one round per cycle, valid/ready on both sides.
module aes_round_sequencer #(
    parameter int unsigned NR   = 10,
    parameter int unsigned RC_W = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [aes_pkg::BLOCK_W-1:0] plaintext,
    input  logic [aes_pkg::BLOCK_W-1:0] key,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [aes_pkg::BLOCK_W-1:0] ciphertext,
    output logic                        busy,
    output logic [RC_W-1:0]             round_idx
);
    import aes_pkg::*;

    if (NR != 10) begin : g_bad_nr
        $error("aes_round_sequencer: only NR=10 (AES-128) is supported");
    end
    if (RC_W < 4) begin : g_bad_rcw
        $error("aes_round_sequencer: RC_W must be at least 4");
    end

    seq_state_e           fsm_q, fsm_d;
    logic [BLOCK_W-1:0]   state_q, state_d;
    logic [BLOCK_W-1:0]   rkey_q, rkey_d;
    logic [BLOCK_W-1:0]   ct_q, ct_d;
    logic [RC_W-1:0]      rnd_q, rnd_d;
    logic                 out_valid_q, out_valid_d;

    logic [BLOCK_W-1:0]   full_state;
    logic [BLOCK_W-1:0]   full_key;
    logic [BLOCK_W-1:0]   fin_state;
    logic [BLOCK_W-1:0]   fin_key;

    aes_round_sequencer_round #(.FINAL(1'b0), .RC_W(RC_W)) rounds (
        .state_i (state_q),
        .key_i   (rkey_q),
        .rc_i    (rnd_q),
        .state_o (full_state),
        .key_o   (full_key)
    );

    aes_round_sequencer_round #(.FINAL(1'b1), .RC_W(RC_W)) finalround (
        .state_i (state_q),
        .key_i   (rkey_q),
        .rc_i    (rnd_q),
        .state_o (fin_state),
        .key_o   (fin_key)
    );

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        rkey_d      = rkey_q;
        ct_d        = ct_q;
        rnd_d       = rnd_q;
        out_valid_d = out_valid_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = plaintext ^ key;
                    rkey_d  = key;
                    rnd_d   = RC_W'(1);
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                // The final-round key is captured too; it is never consumed but keeps the mux symmetric.
                if (rnd_q == RC_W'(NR)) begin
                    ct_d        = fin_state;
                    rkey_d      = fin_key;
                    out_valid_d = 1'b1;
                    fsm_d       = DONE;
                end else begin
                    state_d = full_state;
                    rkey_d  = full_key;
                    rnd_d   = rnd_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    rnd_d       = '0;
                    fsm_d       = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            rkey_q      <= '0;
            ct_q        <= '0;
            rnd_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            rkey_q      <= rkey_d;
            ct_q        <= ct_d;
            rnd_q       <= rnd_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready   = (fsm_q == IDLE);
    assign busy       = (fsm_q != IDLE);
    assign out_valid  = out_valid_q;
    assign ciphertext = ct_q;
    assign round_idx  = rnd_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer using the FIPS-197 App. B and C.1 vectors.
module tb_aes_round_sequencer;

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] plaintext = '0;
    logic [127:0] key = '0;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [127:0] ciphertext;
    logic [3:0]   round_idx;

    int checks = 0;
    int failures = 0;
    int lat;

    always #5 clk = ~clk;

    aes_round_sequencer #(.NR(10), .RC_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy),
        .round_idx  (round_idx)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) step();
        chk("rst_in_ready",  128'(in_ready),  128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_ct",        ciphertext,      128'd0);
        chk("rst_busy",      128'(busy),      128'd0);
        chk("rst_round_idx", 128'(round_idx), 128'd0);
        rst_n = 1'b1;
        step();

        // App. B, with inputs scrambled right after acceptance
        in_valid = 1'b1; plaintext = PT_B; key = KEY_B;
        step();
        chk("b_busy",     128'(busy),      128'd1);
        chk("b_in_ready", 128'(in_ready),  128'd0);
        chk("b_rnd1",     128'(round_idx), 128'd1);
        in_valid = 1'b0; plaintext = ~PT_B; key = PT_C;
        wait_done(lat);
        chk("b_latency",  128'(lat),       128'd10);
        chk("b_ct",       ciphertext,      CT_B);
        chk("b_rnd10",    128'(round_idx), 128'd10);
        chk("b_done_in_ready", 128'(in_ready), 128'd0);
        out_ready = 1'b1;
        step();
        chk("b_handoff_ov",   128'(out_valid), 128'd0);
        chk("b_handoff_ir",   128'(in_ready),  128'd1);
        chk("b_handoff_busy", 128'(busy),      128'd0);
        chk("b_handoff_rnd",  128'(round_idx), 128'd0);
        chk("b_ct_held",      ciphertext,      CT_B);
        out_ready = 1'b0;

        // App. C.1 with round_idx trace
        in_valid = 1'b1; plaintext = PT_C; key = KEY_C;
        step();
        in_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            chk($sformatf("c_rnd%0d", i), 128'(round_idx), 128'(i));
            chk($sformatf("c_ov_early%0d", i), 128'(out_valid), 128'd0);
            step();
        end
        chk("c_out_valid", 128'(out_valid), 128'd1);
        chk("c_ct",        ciphertext,      CT_C);

        // Back-pressure while a second vector waits upstream
        in_valid = 1'b1; plaintext = PT_B; key = KEY_B;
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("bp_ov%0d", i), 128'(out_valid), 128'd1);
            chk($sformatf("bp_ct%0d", i), ciphertext,      CT_C);
            chk($sformatf("bp_ir%0d", i), 128'(in_ready),  128'd0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_release_ov", 128'(out_valid), 128'd0);
        chk("bp_release_ir", 128'(in_ready),  128'd1);
        step();
        chk("b2b_busy", 128'(busy),      128'd1);
        chk("b2b_rnd1", 128'(round_idx), 128'd1);
        wait_done(lat);
        chk("b2b_latency", 128'(lat), 128'd10);
        chk("b2b_ct",      ciphertext, CT_B);
        in_valid = 1'b0;
        step();
        chk("b2b_handoff_ov", 128'(out_valid), 128'd0);
        out_ready = 1'b0;

        // Reset in the middle of round 5
        in_valid = 1'b1; plaintext = PT_C; key = KEY_C;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        chk("mid_rnd5", 128'(round_idx), 128'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ov",   128'(out_valid), 128'd0);
        chk("mid_rst_ct",   ciphertext,      128'd0);
        chk("mid_rst_ir",   128'(in_ready),  128'd1);
        chk("mid_rst_busy", 128'(busy),      128'd0);
        chk("mid_rst_rnd",  128'(round_idx), 128'd0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (12) step();
        chk("post_rst_no_ov", 128'(out_valid), 128'd0);
        in_valid = 1'b1; plaintext = PT_B; key = KEY_B;
        step();
        in_valid = 1'b0;
        wait_done(lat);
        chk("post_rst_latency", 128'(lat), 128'd10);
        chk("post_rst_ct",      ciphertext, CT_B);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
